// File: rtl/des_ks_if.sv
// des_ks_if: key-load and subkey-stream signals between the key register file, des_key_scheduler and the round datapath
// master: drives key_in/key_load/decrypt/subkey_ready and observes the scheduler outputs
// slave:  the scheduler side (des_key_scheduler)
interface des_ks_if;
    logic [63:0] key_in;
    logic        key_load;
    logic        decrypt;
    logic        key_ready;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
    logic        subkey_valid;
    logic        subkey_ready;
    logic        busy;
    logic        done;
    logic        key_err;
    modport master (
        output key_in, key_load, decrypt, subkey_ready,
        input  key_ready, subkey, subkey_round, subkey_valid, busy, done, key_err
    );
    modport slave (
        input  key_in, key_load, decrypt, subkey_ready,
        output key_ready, subkey, subkey_round, subkey_valid, busy, done, key_err
    );
endinterface

// File: rtl/des_key_scheduler.sv
// des_key_scheduler: sequential DES key schedule, emits the 16 PC-2 subkeys of a key one per valid/ready handshake
// Ports: clk, rst (synchronous active-high)
//        ks (des_ks_if.slave): key_in/key_load/decrypt/key_ready accept a key in IDLE,
//        subkey/subkey_round/subkey_valid/subkey_ready stream rounds in encrypt or decrypt order,
//        busy (RUN), done (16th handshake), key_err (parity failure)
// Optional: define DES_KS_PARITY_CHECK_EN to reject keys containing a byte with even parity
module des_key_scheduler (
    input logic     clk,
    input logic     rst,
    des_ks_if.slave ks
);
    localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2 [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state, state_n;
    logic [55:0] cd, cd_pc1, next_cd;
    logic [47:0] key_pc2, subkey;
    logic [4:0]  cnt;
    logic [3:0]  round;
    logic        dec, valid, none, one, parity_ok, accept, fire, hs_last;
    // bit n of the DES numbering (1 = MSB) lives at vector index width-n
    for (genvar i = 0; i < 56; i++) begin : g_pc1
        assign cd_pc1[55 - i] = ks.key_in[64 - PC1[i]];
    end
    for (genvar i = 0; i < 48; i++) begin : g_pc2
        assign key_pc2[47 - i] = next_cd[56 - PC2[i]];
    end
    function automatic logic [27:0] rot(input logic [27:0] x, input logic n, input logic o, input logic r);
        return n ? x : r ? (o ? {x[0], x[27:1]} : {x[1:0], x[27:2]})
                         : (o ? {x[26:0], x[27]} : {x[25:0], x[27:26]});
    endfunction
    always_comb begin
        // decrypt walks the schedule backwards: round 0 uses the unrotated halves (C16 = C0)
        none    = dec && cnt[3:0] == 4'd0;
        one     = cnt[3:0] == 4'd1 || cnt[3:0] == 4'd8 || cnt[3:0] == 4'd15 || (!dec && cnt[3:0] == 4'd0);
        next_cd = {rot(cd[55:28], none, one, dec), rot(cd[27:0], none, one, dec)};
        accept  = state == IDLE && ks.key_load;
        fire    = state == RUN && !cnt[4] && (!valid || ks.subkey_ready);
        hs_last = valid && ks.subkey_ready && cnt[4];
        state_n = accept && parity_ok ? RUN : hs_last ? IDLE : state;
    end
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    always_ff @(posedge clk) begin
        if (rst) begin
            cd     <= '0;
            dec    <= 1'b0;
            cnt    <= '0;
            subkey <= '0;
            round  <= '0;
            valid  <= 1'b0;
        end else if (accept) begin
            cd    <= cd_pc1;
            dec   <= ks.decrypt;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (fire) begin
            cd     <= next_cd;
            subkey <= key_pc2;
            round  <= cnt[3:0];
            cnt    <= cnt + 5'd1;
            valid  <= 1'b1;
        end else if (hs_last) begin
            valid <= 1'b0;
        end
    end
    assign ks.key_ready    = state == IDLE;
    assign ks.busy         = state == RUN;
    assign ks.subkey       = subkey;
    assign ks.subkey_round = round;
    assign ks.subkey_valid = valid;
    assign ks.done         = hs_last;
`ifdef DES_KS_PARITY_CHECK_EN
    logic [7:0] byte_ok;
    logic       err;
    for (genvar i = 0; i < 8; i++) begin : g_par
        assign byte_ok[i] = ^ks.key_in[8*i +: 8];
    end
    assign parity_ok = &byte_ok;
    always_ff @(posedge clk) err <= rst ? 1'b0 : accept ? !parity_ok : err;
    assign ks.key_err = err;
`else
    assign parity_ok  = 1'b1;
    assign ks.key_err = 1'b0;
`endif
endmodule

// File: tb/tb_des_key_scheduler.sv
// tb_des_key_scheduler: directed checks of des_key_scheduler against the published subkeys of key 133457799BBCDFF1
module tb_des_key_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    des_ks_if ks ();
    des_key_scheduler dut (.clk(clk), .rst(rst), .ks(ks.slave));
    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    logic [47:0] kt [16] = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                             48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                             48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                             48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
    int vecs = 0;
    int miss = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        assert (got === exp) else begin
            miss++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic load(input logic [63:0] key, input logic dec);
        int n = 0;
        while (!ks.key_ready && n < 50) begin
            tick();
            n++;
        end
        chk("load_ready", ks.key_ready, 1);
        ks.key_in   = key;
        ks.decrypt  = dec;
        ks.key_load = 1'b1;
        tick();
        ks.key_load = 1'b0;
        ks.decrypt  = ~dec;
    endtask
    task automatic started();
        chk("run_busy", ks.busy, 1);
        chk("run_key_ready", ks.key_ready, 0);
        chk("run_valid", ks.subkey_valid, 0);
    endtask
    task automatic stream(input logic dec, input int stop, input bit bp, input bit inject);
        int r = 0;
        int st7 = 0;
        bit held_v = 0;
        logic [47:0] hk = '0;
        logic [3:0] hr = '0;
        for (int k = 1; k <= 300 && r < stop; k++) begin
            tick();
            if (held_v) begin
                chk("stall_subkey", ks.subkey, hk);
                chk("stall_round", ks.subkey_round, hr);
            end
            ks.key_in   = '0;
            ks.key_load = inject && (k == 6 || k == 16);
            if (!bp) ks.subkey_ready = 1'b1;
            else if (ks.subkey_valid && ks.subkey_round == 4'd7 && st7 < 5) begin
                ks.subkey_ready = 1'b0;
                st7++;
            end else ks.subkey_ready = 1'($urandom_range(0, 1));
            #1;
            held_v = ks.subkey_valid && !ks.subkey_ready;
            hk = ks.subkey;
            hr = ks.subkey_round;
            if (ks.subkey_valid && ks.subkey_ready) begin
                chk("subkey", ks.subkey, dec ? kt[15 - r] : kt[r]);
                chk("round", ks.subkey_round, r);
                chk("done", ks.done, r == 15);
                chk("busy", ks.busy, 1);
                if (!bp) chk("hs_cycle", k, r + 1);
                r++;
            end else chk("done_quiet", ks.done, 0);
        end
        ks.key_load = 1'b0;
        chk("handshakes", r, stop);
        if (bp) chk("stall7_len", st7, 5);
    endtask
    task automatic finished();
        tick();
        chk("end_valid", ks.subkey_valid, 0);
        chk("end_busy", ks.busy, 0);
        chk("end_key_ready", ks.key_ready, 1);
        chk("end_done", ks.done, 0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        ks.key_in = '0;
        ks.key_load = 1'b0;
        ks.decrypt = 1'b0;
        ks.subkey_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_key_ready", ks.key_ready, 1);
        chk("rst_busy", ks.busy, 0);
        chk("rst_valid", ks.subkey_valid, 0);
        chk("rst_done", ks.done, 0);
        chk("rst_subkey", ks.subkey, 0);
        chk("rst_round", ks.subkey_round, 0);
        chk("rst_key_err", ks.key_err, 0);
        tick();
        chk("idle_valid", ks.subkey_valid, 0);
        load(KEY, 1'b0);
        started();
        stream(1'b0, 16, 1'b0, 1'b0);
        finished();
        load(KEY, 1'b0);
        started();
        stream(1'b0, 16, 1'b0, 1'b1);
        finished();
        load(KEY, 1'b0);
        started();
        stream(1'b0, 16, 1'b1, 1'b0);
        finished();
        load(KEY, 1'b0);
        started();
        stream(1'b0, 5, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", ks.subkey_valid, 0);
        chk("midrst_busy", ks.busy, 0);
        chk("midrst_key_ready", ks.key_ready, 1);
        chk("midrst_done", ks.done, 0);
        chk("midrst_subkey", ks.subkey, 0);
        tick();
        chk("midrst_idle", ks.subkey_valid, 0);
        load(KEY, 1'b1);
        started();
        stream(1'b1, 16, 1'b0, 1'b0);
        finished();
`ifdef DES_KS_PARITY_CHECK_EN
        load(KEY ^ 64'd1, 1'b0);
        chk("par_err", ks.key_err, 1);
        chk("par_busy", ks.busy, 0);
        chk("par_key_ready", ks.key_ready, 1);
        tick();
        tick();
        chk("par_no_valid", ks.subkey_valid, 0);
        chk("par_err_hold", ks.key_err, 1);
        load(KEY, 1'b0);
        chk("par_clear", ks.key_err, 0);
        started();
        stream(1'b0, 16, 1'b0, 1'b0);
        finished();
`else
        load(KEY ^ 64'd1, 1'b0);
        chk("nopar_err", ks.key_err, 0);
        started();
        stream(1'b0, 16, 1'b0, 1'b0);
        finished();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
